cp0_nway: RTL and testbench
===========================

# cp0_nway

Parametrised coprocessor-0 register file for the N-issue in-order pipeline. Holds the MIPS32 CP0 state (status, cause, EPC, count/compare, BadVAddr, PRId, Config/Config1 and the TLB register set), services N same-cycle mfc0/mtc0 slots, applies commit-stage exceptions, ERET, TLBR and TLBP, runs count/random/timer, and raises the interrupt request to the commit stage.

## Interface
- ISSUE_W, 2: number of read/write slots; slot index i+1 is younger than slot i.
- TLB_ENTRIES, 16: TLB size, power of two, 2..32; IDX_W = log2(TLB_ENTRIES).
- COUNT_DIV, 2: Count increments once every COUNT_DIV cycles, 1..16.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- cwen  in  ISSUE_W  mtc0 write enable per slot
- caddr, raddr  in  ISSUE_W×5  write/read register number per slot
- csel, rsel  in  ISSUE_W×3  write/read select per slot
- cwdata  in  ISSUE_W×32  write data per slot
- rdata  out  ISSUE_W×32  read data per slot, combinational
- exc_valid, exc_bd  in  1  exception commit; faulting instruction in delay slot
- exc_code  in  5  ExcCode
- exc_pc, exc_badvaddr  in  32  faulting PC; faulting address
- eret, tlbr, tlbp  in  1  commit strobes
- tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1  in  32  TLB read data
- tlbp_index  in  32  probe result (P bit 31, index low bits)
- hw_int  in  6  external interrupt lines, level sensitive
- int_req  out  1  interrupt pending and enabled
- status_o, cause_o, epc_o, entryhi_o, entrylo0_o, entrylo1_o, index_o, random_o  out  32  current register values
- k0_uncached  out  1  Config.K0 != 3'b011

## Operation
- Reads: rdata[i] = register (raddr[i], rsel[i]) as currently registered; no write bypass. (16,1) = Config1; unimplemented numbers/selects read 0.
- Writes only honoured with csel=0; writable fields: Index.index, EntryLo0/1[25:0], Context.PTEBase, Wired, Count, EntryHi VPN2/ASID, Compare, Status IM/EXL/IE, Cause IP[1:0], EPC, Config K0. Other bits read-only.
- Same-register writes in one cycle: highest slot index wins.
- Update priority within a cycle (later overrides): mtc0 slots < TLBR/TLBP < exception < ERET. exc_valid with eret: eret ignored.
- Exception: if Status.EXL=0, EPC = exc_bd ? exc_pc−4 : exc_pc and Cause.BD = exc_bd; if EXL=1 EPC/BD unchanged. Always Cause.ExcCode = exc_code, EXL=1. Codes 1,2,3 (Mod/TLBL/TLBS) load BadVAddr, Context.BadVPN2 and EntryHi.VPN2; codes 4,5 load BadVAddr only.
- ERET: clear ERL if set, else clear EXL.
- Cause.IP[7:2] = hw_int registered each cycle, with IP[7] ORed with Cause.TI.
- Timer: TI sets in the cycle Count becomes equal to Compare; mtc0 to Compare clears TI, clear wins over same-cycle set.
- Random: decrements each cycle; at value == Wired (or 0) reloads TLB_ENTRIES−1; mtc0 to Wired also reloads TLB_ENTRIES−1.
- int_req = |(Cause.IP & Status.IM) & IE & ~EXL & ~ERL, from registered state.
- Reset values: Status 0x0040_0004 (BEV, ERL), Cause 0, Count 0, Compare 0, EPC 0, Wired 0, Random TLB_ENTRIES−1, Index 0, PRId 0x0000_4220, Config K0=3'b010, Config1 MMU-size = TLB_ENTRIES−1; all outputs reflect these; int_req 0.

## Timing
- Writes, exceptions, ERET, TLB ops visible on rdata/outputs the cycle after the strobe.
- Count divider phase restarts at reset and on mtc0 Count; an mtc0 Count value takes priority over that cycle's increment.
- Count wraps 0xFFFF_FFFF → 0.
- hw_int to int_req latency: 1 cycle.
- Reset mid-operation discards same-cycle strobes.

## Configuration
- CP0_TLB_EN defined: Index, Random, EntryLo0/1, Context, Wired, EntryHi implemented, tlbr/tlbp honoured.
- Undefined: those registers read 0, writes and tlbr/tlbp ignored, TLB exception codes update only BadVAddr, Config1 MMU-size = 0, random_o/index_o/entry*_o tie to 0.

## Test plan
- After reset, read (12,0) → 0x0040_0004, (16,1) MMU-size 15; int_req 0.
- Slots 0 and 1 both mtc0 EPC with 0x100/0x200 → EPC 0x200 next cycle.
- exc_valid, code 2, bd=1, pc 0xBFC0_0104, badvaddr 0x1234_5000 with EXL=0 → EPC 0xBFC0_0100, BD 1, EXL 1, EntryHi.VPN2 0x091A2; second exception → EPC unchanged.
- Compare=20, COUNT_DIV=2 → TI and int_req (IM7, IE set, EXL/ERL clear) after Count reaches 20; mtc0 Compare → TI cleared next cycle.
- Wired=4 → Random sequence 15..4 then 15; exc_valid with eret same cycle → EXL stays 1.
- Build without CP0_TLB_EN: tlbr strobe, read (10,0) → 0.

Source files
------------

// File: rtl/cp0_nway.sv
// cp0_nway: MIPS32 coprocessor-0 register file for an N-issue in-order pipe.
// N combinational mfc0 read ports and N mtc0 write slots (younger slot wins).
// Commit-stage exception/ERET/TLBR/TLBP, Count/Compare timer, Random, int_req.
// Ports: clk, reset (sync, active-low); cwen/caddr/csel/cwdata write slots;
//   raddr/rsel/rdata read slots; exc_* exception commit; eret/tlbr/tlbp
//   strobes with tlbr_*/tlbp_index data; hw_int lines; int_req; *_o views.
// Build option: define CP0_TLB_EN to implement the TLB register set.
module cp0_nway #(
    parameter int ISSUE_W     = 2,
    parameter int TLB_ENTRIES = 16,
    parameter int COUNT_DIV   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ISSUE_W-1:0]       cwen,
    input  logic [ISSUE_W-1:0][4:0]  caddr,
    input  logic [ISSUE_W-1:0][2:0]  csel,
    input  logic [ISSUE_W-1:0][31:0] cwdata,
    input  logic [ISSUE_W-1:0][4:0]  raddr,
    input  logic [ISSUE_W-1:0][2:0]  rsel,
    output logic [ISSUE_W-1:0][31:0] rdata,
    input  logic                     exc_valid,
    input  logic                     exc_bd,
    input  logic [4:0]               exc_code,
    input  logic [31:0]              exc_pc,
    input  logic [31:0]              exc_badvaddr,
    input  logic                     eret,
    input  logic                     tlbr,
    input  logic                     tlbp,
    input  logic [31:0]              tlbr_entryhi,
    input  logic [31:0]              tlbr_entrylo0,
    input  logic [31:0]              tlbr_entrylo1,
    input  logic [31:0]              tlbp_index,
    input  logic [5:0]               hw_int,
    output logic                     int_req,
    output logic [31:0]              status_o,
    output logic [31:0]              cause_o,
    output logic [31:0]              epc_o,
    output logic [31:0]              entryhi_o,
    output logic [31:0]              entrylo0_o,
    output logic [31:0]              entrylo1_o,
    output logic [31:0]              index_o,
    output logic [31:0]              random_o,
    output logic                     k0_uncached
);
`ifdef CP0_TLB_EN
    localparam bit TLB_EN = 1'b1;
`else
    localparam bit TLB_EN = 1'b0;
`endif
    localparam int IDX_W = $clog2(TLB_ENTRIES);
    localparam logic [IDX_W-1:0] RND_MAX = '1;
    localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);
    localparam logic [5:0] MMU_SIZE = TLB_EN ? 6'(TLB_ENTRIES - 1) : 6'd0;

    logic             index_p_q, index_p_n;
    logic [IDX_W-1:0] index_q, index_n, random_q, random_n, wired_q, wired_n;
    logic [25:0]      lo0_q, lo0_n, lo1_q, lo1_n;
    logic [8:0]       pte_base_q, pte_base_n;
    logic [18:0]      badvpn2_q, badvpn2_n, vpn2_q, vpn2_n;
    logic [7:0]       asid_q, asid_n, im_q, im_n;
    logic [31:0]      badvaddr_q, badvaddr_n, count_q, count_n;
    logic [31:0]      compare_q, compare_n, epc_q, epc_n;
    logic [3:0]       div_q, div_n;
    logic             exl_q, exl_n, ie_q, ie_n, erl_q, erl_n;
    logic             bd_q, bd_n, ti_q, ti_n;
    logic [5:0]       hw_q;
    logic [1:0]       sw_ip_q, sw_ip_n;
    logic [4:0]       code_q, code_n;
    logic [2:0]       k0_q, k0_n;
    logic             count_chg, cmp_wr, wired_wr, mmu_code, bad_code;

    always_comb begin
        index_p_n  = index_p_q;
        index_n    = index_q;
        wired_n    = wired_q;
        lo0_n      = lo0_q;
        lo1_n      = lo1_q;
        pte_base_n = pte_base_q;
        badvpn2_n  = badvpn2_q;
        vpn2_n     = vpn2_q;
        asid_n     = asid_q;
        im_n       = im_q;
        badvaddr_n = badvaddr_q;
        compare_n  = compare_q;
        epc_n      = epc_q;
        exl_n      = exl_q;
        ie_n       = ie_q;
        erl_n      = erl_q;
        bd_n       = bd_q;
        sw_ip_n    = sw_ip_q;
        code_n     = code_q;
        k0_n       = k0_q;
        cmp_wr     = 1'b0;
        wired_wr   = 1'b0;
        // free-running divider; a Count write below restarts the phase
        count_chg  = (div_q == DIV_LAST);
        div_n      = count_chg ? 4'd0 : div_q + 4'd1;
        count_n    = count_chg ? count_q + 32'd1 : count_q;
        random_n   = (random_q == wired_q || random_q == '0) ? RND_MAX
                                                            : random_q - 1'b1;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (cwen[i] && csel[i] == 3'd0) begin
                case (caddr[i])
                    5'd0:  index_n = cwdata[i][IDX_W-1:0];
                    5'd2:  lo0_n = cwdata[i][25:0];
                    5'd3:  lo1_n = cwdata[i][25:0];
                    5'd4:  pte_base_n = cwdata[i][31:23];
                    5'd6: begin
                        wired_n  = cwdata[i][IDX_W-1:0];
                        wired_wr = 1'b1;
                    end
                    5'd9: begin
                        count_n   = cwdata[i];
                        div_n     = 4'd0;
                        count_chg = 1'b1;
                    end
                    5'd10: begin
                        vpn2_n = cwdata[i][31:13];
                        asid_n = cwdata[i][7:0];
                    end
                    5'd11: begin
                        compare_n = cwdata[i];
                        cmp_wr    = 1'b1;
                    end
                    5'd12: begin
                        im_n  = cwdata[i][15:8];
                        exl_n = cwdata[i][1];
                        ie_n  = cwdata[i][0];
                    end
                    5'd13: sw_ip_n = cwdata[i][9:8];
                    5'd14: epc_n = cwdata[i];
                    5'd16: k0_n = cwdata[i][2:0];
                    default: ;
                endcase
            end
        end
        if (wired_wr) random_n = RND_MAX;
        // match is against the Compare value held before this edge
        ti_n = ti_q | (count_chg && count_n == compare_q);
        if (cmp_wr) ti_n = 1'b0;
        if (TLB_EN && tlbr) begin
            vpn2_n = tlbr_entryhi[31:13];
            asid_n = tlbr_entryhi[7:0];
            lo0_n  = tlbr_entrylo0[25:0];
            lo1_n  = tlbr_entrylo1[25:0];
        end
        if (TLB_EN && tlbp) begin
            index_p_n = tlbp_index[31];
            index_n   = tlbp_index[IDX_W-1:0];
        end
        mmu_code = exc_code == 5'd1 || exc_code == 5'd2 || exc_code == 5'd3;
        bad_code = mmu_code || exc_code == 5'd4 || exc_code == 5'd5;
        if (exc_valid) begin
            if (!exl_q) begin
                epc_n = exc_bd ? exc_pc - 32'd4 : exc_pc;
                bd_n  = exc_bd;
            end
            code_n = exc_code;
            exl_n  = 1'b1;
            if (bad_code) badvaddr_n = exc_badvaddr;
            if (TLB_EN && mmu_code) begin
                badvpn2_n = exc_badvaddr[31:13];
                vpn2_n    = exc_badvaddr[31:13];
            end
        end else if (eret) begin
            if (erl_q) erl_n = 1'b0;
            else       exl_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            index_p_q  <= 1'b0;
            index_q    <= '0;
            random_q   <= RND_MAX;
            wired_q    <= '0;
            lo0_q      <= '0;
            lo1_q      <= '0;
            pte_base_q <= '0;
            badvpn2_q  <= '0;
            vpn2_q     <= '0;
            asid_q     <= '0;
            im_q       <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            div_q      <= '0;
            compare_q  <= '0;
            epc_q      <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            erl_q      <= 1'b1;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            hw_q       <= '0;
            sw_ip_q    <= '0;
            code_q     <= '0;
            k0_q       <= 3'b010;
        end else begin
            index_p_q  <= index_p_n;
            index_q    <= index_n;
            random_q   <= random_n;
            wired_q    <= wired_n;
            lo0_q      <= lo0_n;
            lo1_q      <= lo1_n;
            pte_base_q <= pte_base_n;
            badvpn2_q  <= badvpn2_n;
            vpn2_q     <= vpn2_n;
            asid_q     <= asid_n;
            im_q       <= im_n;
            badvaddr_q <= badvaddr_n;
            count_q    <= count_n;
            div_q      <= div_n;
            compare_q  <= compare_n;
            epc_q      <= epc_n;
            exl_q      <= exl_n;
            ie_q       <= ie_n;
            erl_q      <= erl_n;
            bd_q       <= bd_n;
            ti_q       <= ti_n;
            hw_q       <= hw_int;
            sw_ip_q    <= sw_ip_n;
            code_q     <= code_n;
            k0_q       <= k0_n;
        end
    end

    logic [7:0]  ip;
    logic [31:0] context_w, wired_w;
    logic        unused_bits;

    assign ip = {hw_q[5] | ti_q, hw_q[4:0], sw_ip_q};
    assign status_o = {9'd0, 1'b1, 6'd0, im_q, 5'd0, erl_q, exl_q, ie_q};
    assign cause_o = {bd_q, ti_q, 14'd0, ip, 1'b0, code_q, 2'b00};
    assign epc_o = epc_q;
    assign entryhi_o = TLB_EN ? {vpn2_q, 5'd0, asid_q} : '0;
    assign entrylo0_o = TLB_EN ? {6'd0, lo0_q} : '0;
    assign entrylo1_o = TLB_EN ? {6'd0, lo1_q} : '0;
    assign index_o = TLB_EN ? {index_p_q, 31'(index_q)} : '0;
    assign random_o = TLB_EN ? 32'(random_q) : '0;
    assign context_w = TLB_EN ? {pte_base_q, badvpn2_q, 4'd0} : '0;
    assign wired_w = TLB_EN ? 32'(wired_q) : '0;
    assign k0_uncached = k0_q != 3'b011;
    assign int_req = |(ip & im_q) & ie_q & ~exl_q & ~erl_q;
    assign unused_bits = ^{tlbr_entryhi[12:8], tlbr_entrylo0[31:26],
                           tlbr_entrylo1[31:26], tlbp_index[30:IDX_W]};

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            rdata[i] = '0;
            if (rsel[i] == 3'd0) begin
                case (raddr[i])
                    5'd0:  rdata[i] = index_o;
                    5'd1:  rdata[i] = random_o;
                    5'd2:  rdata[i] = entrylo0_o;
                    5'd3:  rdata[i] = entrylo1_o;
                    5'd4:  rdata[i] = context_w;
                    5'd6:  rdata[i] = wired_w;
                    5'd8:  rdata[i] = badvaddr_q;
                    5'd9:  rdata[i] = count_q;
                    5'd10: rdata[i] = entryhi_o;
                    5'd11: rdata[i] = compare_q;
                    5'd12: rdata[i] = status_o;
                    5'd13: rdata[i] = cause_o;
                    5'd14: rdata[i] = epc_q;
                    5'd15: rdata[i] = 32'h0000_4220;
                    5'd16: rdata[i] = {29'd0, k0_q};
                    default: ;
                endcase
            end else if (rsel[i] == 3'd1 && raddr[i] == 5'd16) begin
                rdata[i] = {1'b0, MMU_SIZE, 25'd0};
            end
        end
    end
endmodule

// File: tb/tb_cp0_nway.sv
// tb_cp0_nway: randomized + directed bench for cp0_nway against a
// register-level reference model (whole 32-bit registers with write masks).
module tb_cp0_nway;
`ifdef CP0_TLB_EN
    localparam bit TLB = 1'b1;
`else
    localparam bit TLB = 1'b0;
`endif
    localparam int N = 2;
    localparam int CDIV = 2;
    localparam logic [31:0] TMAX = 32'd15;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] cwen;
    logic [N-1:0][4:0] caddr, raddr;
    logic [N-1:0][2:0] csel, rsel;
    logic [N-1:0][31:0] cwdata, rdata;
    logic exc_valid, exc_bd, eret, tlbr, tlbp;
    logic [4:0] exc_code;
    logic [31:0] exc_pc, exc_badvaddr;
    logic [31:0] tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1, tlbp_index;
    logic [5:0] hw_int;
    logic int_req, k0_uncached;
    logic [31:0] status_o, cause_o, epc_o, entryhi_o;
    logic [31:0] entrylo0_o, entrylo1_o, index_o, random_o;

    cp0_nway #(.ISSUE_W(N), .TLB_ENTRIES(16), .COUNT_DIV(CDIV)) dut (
        .clk(clk), .reset(reset),
        .cwen(cwen), .caddr(caddr), .csel(csel), .cwdata(cwdata),
        .raddr(raddr), .rsel(rsel), .rdata(rdata),
        .exc_valid(exc_valid), .exc_bd(exc_bd), .exc_code(exc_code),
        .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr),
        .eret(eret), .tlbr(tlbr), .tlbp(tlbp),
        .tlbr_entryhi(tlbr_entryhi), .tlbr_entrylo0(tlbr_entrylo0),
        .tlbr_entrylo1(tlbr_entrylo1), .tlbp_index(tlbp_index),
        .hw_int(hw_int), .int_req(int_req),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o),
        .entrylo1_o(entrylo1_o), .index_o(index_o), .random_o(random_o),
        .k0_uncached(k0_uncached)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    // reference model: m[r] is the architectural view of register (r,0)
    logic [31:0] m [17];
    int ph;

    function automatic logic [31:0] wmask(input int a);
        case (a)
            0, 6:    return TMAX;
            2, 3:    return 32'h03FF_FFFF;
            4:       return 32'hFF80_0000;
            9,11,14: return 32'hFFFF_FFFF;
            10:      return 32'hFFFF_E0FF;
            12:      return 32'h0000_FF03;
            13:      return 32'h0000_0300;
            16:      return 32'h0000_0007;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_tlb(input int a);
        return a inside {0, 1, 2, 3, 4, 6, 10};
    endfunction

    function automatic logic [31:0] mread(input int a, input int s);
        if (s == 1 && a == 16) return TLB ? 32'h1E00_0000 : 32'h0;
        if (s != 0 || a > 16 || a == 5 || a == 7) return 0;
        if (is_tlb(a) && !TLB) return 0;
        return m[a];
    endfunction

    function automatic logic m_int();
        return ((m[13][15:8] & m[12][15:8]) != 0) && m[12][0]
               && !m[12][1] && !m[12][2];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 17; r++) m[r] = 0;
        m[12] = 32'h0040_0004;
        m[1] = TMAX;
        m[15] = 32'h0000_4220;
        m[16] = 32'h2;
        ph = 0;
    endtask

    task automatic model_step();
        logic [31:0] n [17];
        logic [31:0] mk, rnd;
        int a, ph_n;
        bit chg, cmp_wr, ti;
        n = m;
        chg = 0;
        cmp_wr = 0;
        ph_n = ph + 1;
        if (ph_n == CDIV) begin
            n[9] = m[9] + 1;
            ph_n = 0;
            chg = 1;
        end
        rnd = (m[1] == m[6] || m[1] == 0) ? TMAX : m[1] - 1;
        for (int i = 0; i < N; i++) begin
            a = int'(caddr[i]);
            mk = wmask(a);
            if (cwen[i] && csel[i] == 0 && mk != 0) begin
                n[a] = (n[a] & ~mk) | (cwdata[i] & mk);
                if (a == 6) rnd = TMAX;
                if (a == 9) begin ph_n = 0; chg = 1; end
                if (a == 11) cmp_wr = 1;
            end
        end
        n[1] = rnd;
        ti = m[13][30];
        if (chg && n[9] == m[11]) ti = 1;
        if (cmp_wr) ti = 0;
        if (TLB && tlbr) begin
            n[10] = tlbr_entryhi & 32'hFFFF_E0FF;
            n[2] = tlbr_entrylo0 & 32'h03FF_FFFF;
            n[3] = tlbr_entrylo1 & 32'h03FF_FFFF;
        end
        if (TLB && tlbp) n[0] = tlbp_index & (32'h8000_0000 | TMAX);
        if (exc_valid) begin
            if (!m[12][1]) begin
                n[14] = exc_bd ? exc_pc - 4 : exc_pc;
                n[13][31] = exc_bd;
            end
            n[13][6:2] = exc_code;
            n[12][1] = 1'b1;
            if (exc_code >= 1 && exc_code <= 5) n[8] = exc_badvaddr;
            if (TLB && exc_code >= 1 && exc_code <= 3) begin
                n[10][31:13] = exc_badvaddr[31:13];
                n[4][22:4] = exc_badvaddr[31:13];
            end
        end else if (eret) begin
            if (m[12][2]) n[12][2] = 1'b0;
            else n[12][1] = 1'b0;
        end
        n[13][30] = ti;
        n[13][14:10] = hw_int[4:0];
        n[13][15] = hw_int[5] | ti;
        m = n;
        ph = ph_n;
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++)
            check($sformatf("rdata%0d(%0d,%0d)", i, raddr[i], rsel[i]),
                  rdata[i], mread(int'(raddr[i]), int'(rsel[i])));
        check("status_o", status_o, m[12]);
        check("cause_o", cause_o, m[13]);
        check("epc_o", epc_o, m[14]);
        check("entryhi_o", entryhi_o, TLB ? m[10] : 0);
        check("entrylo0_o", entrylo0_o, TLB ? m[2] : 0);
        check("entrylo1_o", entrylo1_o, TLB ? m[3] : 0);
        check("index_o", index_o, TLB ? m[0] : 0);
        check("random_o", random_o, TLB ? m[1] : 0);
        check("int_req", 32'(int_req), 32'(m_int()));
        check("k0_uncached", 32'(k0_uncached), 32'(m[16][2:0] != 3));
    endtask

    task automatic idle();
        reset = 1'b1;
        cwen = '0;
        exc_valid = 0;
        eret = 0;
        tlbr = 0;
        tlbp = 0;
    endtask

    // inputs are set at the falling edge; model follows the rising edge
    task automatic tick();
        #1;
        check_all();
        if (!reset) model_reset();
        else model_step();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input int s, input int a, input logic [31:0] d);
        cwen[s] = 1'b1;
        caddr[s] = 5'(a);
        csel[s] = 3'd0;
        cwdata[s] = d;
    endtask

    task automatic rd(input int s, input int a, input int sl);
        raddr[s] = 5'(a);
        rsel[s] = 3'(sl);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=%0d exp=%0d", n_chk, 0);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp;
        int regs [16] = '{0, 1, 2, 3, 4, 6, 8, 9, 10, 11, 12, 13, 14, 15,
                          16, 5};
        idle();
        caddr = '0; csel = '0; cwdata = '0; raddr = '0; rsel = '0;
        exc_bd = 0; exc_code = 0; exc_pc = 0; exc_badvaddr = 0;
        tlbr_entryhi = 0; tlbr_entrylo0 = 0; tlbr_entrylo1 = 0;
        tlbp_index = 0; hw_int = 0;
        model_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        // reset state
        rd(0, 12, 0);
        rd(1, 16, 1);
        #1;
        check("rst_status", rdata[0], 32'h0040_0004);
        check("rst_mmusize", 32'(rdata[1][30:25]), TLB ? 32'd15 : 32'd0);
        check("rst_int_req", 32'(int_req), 0);
        check("rst_random", random_o, TLB ? 32'd15 : 32'd0);
        check("rst_cause", cause_o, 0);
        // two slots write EPC: younger wins
        wr(0, 14, 32'h100);
        wr(1, 14, 32'h200);
        tick();
        check("epc_dual", epc_o, 32'h200);
        // TLBL in delay slot with EXL clear
        exc_valid = 1; exc_code = 2; exc_bd = 1;
        exc_pc = 32'hBFC0_0104; exc_badvaddr = 32'h1234_5000;
        rd(0, 8, 0);
        tick();
        check("exc_epc", epc_o, 32'hBFC0_0100);
        check("exc_bd", 32'(cause_o[31]), 1);
        check("exc_exl", 32'(status_o[1]), 1);
        check("exc_code", 32'(cause_o[6:2]), 2);
        check("exc_vpn2", 32'(entryhi_o[31:13]), TLB ? 32'h091A2 : 0);
        check("exc_badva", rdata[0], 32'h1234_5000);
        exc_valid = 1; exc_code = 4; exc_bd = 0;
        exc_pc = 32'h8000_0000; exc_badvaddr = 32'h0000_0abc;
        tick();
        check("exc2_epc", epc_o, 32'hBFC0_0100);
        check("exc2_code", 32'(cause_o[6:2]), 4);
        // ERET clears ERL first, then EXL
        eret = 1;
        tick();
        check("eret_erl", 32'(status_o[2:1]), 32'b01);
        eret = 1;
        tick();
        check("eret_exl", 32'(status_o[1]), 0);
        exc_valid = 1; exc_code = 0; eret = 1;
        tick();
        check("exc_eret_exl", 32'(status_o[1]), 1);
        eret = 1;
        tick();
        // timer: Compare 20 with Count restarted at 0
        wr(0, 11, 32'd20);
        wr(1, 9, 32'd0);
        tick();
        wr(0, 12, 32'h0000_8001);
        tick();
        rd(0, 9, 0);
        for (int k = 0; k < 200 && !cause_o[30]; k++) tick();
        check("ti_set", 32'(cause_o[30]), 1);
        check("ti_count", rdata[0], 32'd20);
        check("ti_int_req", 32'(int_req), 1);
        wr(0, 11, 32'd1000);
        tick();
        check("ti_clear", 32'(cause_o[30]), 0);
        check("ti_int_off", 32'(int_req), 0);
        // hardware line to int_req in one cycle
        wr(0, 12, 32'h0000_0401);
        tick();
        hw_int = 6'b000001;
        #1;
        check("hw_before", 32'(int_req), 0);
        tick();
        check("hw_after", 32'(int_req), 1);
        hw_int = 0;
        tick();
        // Random walk with Wired = 4
        wr(1, 6, 32'd4);
        tick();
        exp = 15;
        for (int k = 0; k < 14; k++) begin
            check("random_seq", random_o, TLB ? exp : 0);
            exp = (exp == 4) ? 15 : exp - 1;
            tick();
        end
        // Count wrap
        wr(0, 9, 32'hFFFF_FFFF);
        rd(0, 9, 0);
        tick();
        check("cnt_max", rdata[0], 32'hFFFF_FFFF);
        tick();
        tick();
        check("cnt_wrap", rdata[0], 0);
        // TLB read / probe
        tlbr = 1;
        tlbr_entryhi = 32'hDEAD_BEEF;
        tlbr_entrylo0 = 32'hFFFF_FFFF;
        tlbr_entrylo1 = 32'h0123_4567;
        rd(0, 10, 0);
        tick();
        check("tlbr_hi", rdata[0], TLB ? 32'hDEAD_A0EF : 0);
        tlbp = 1;
        tlbp_index = 32'h8000_0005;
        tick();
        check("tlbp_idx", index_o, TLB ? 32'h8000_0005 : 0);
        // reset discards same-cycle strobes
        wr(0, 14, 32'h1234);
        exc_valid = 1;
        reset = 0;
        tick();
        check("rst_mid_epc", epc_o, 0);
        check("rst_mid_st", status_o, 32'h0040_0004);
        // randomized traffic
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                cwen[i] = ($urandom_range(0, 2) == 0);
                caddr[i] = 5'(regs[$urandom_range(0, 15)]);
                csel[i] = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0;
                cwdata[i] = $urandom;
                raddr[i] = 5'($urandom_range(0, 18));
                rsel[i] = ($urandom_range(0, 5) == 0) ? 3'd1 : 3'd0;
            end
            exc_valid = ($urandom_range(0, 15) == 0);
            exc_code = 5'($urandom_range(0, 7));
            exc_bd = 1'($urandom);
            exc_pc = $urandom;
            exc_badvaddr = $urandom;
            eret = ($urandom_range(0, 11) == 0);
            tlbr = ($urandom_range(0, 15) == 0);
            tlbp = ($urandom_range(0, 15) == 0);
            tlbr_entryhi = $urandom;
            tlbr_entrylo0 = $urandom;
            tlbr_entrylo1 = $urandom;
            tlbp_index = $urandom;
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
            if ($urandom_range(0, 199) == 0) reset = 0;
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
